// File: rtl/rv_decode_ex_ctrl.sv
// RV32I-subset control path: Decode-stage main/ALU decoder, the
// Decode->Execute control register, and the Execute-stage ALU.
package rv_decode_ex_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic [2:0] alu_control;
        logic       alu_src;
    } id_ex_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

module rv_decode_ex_ctrl
    import rv_decode_ex_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_e,
    input  logic [6:0]      op,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    output logic            RegWriteD,
    output logic [1:0]      ResultSrcD,
    output logic            MemWriteD,
    output logic            JumpD,
    output logic            BranchD,
    output logic [2:0]      ALUControlD,
    output logic            ALUSrcD,
    output logic [1:0]      ImmSrcD,
    output logic            RegWriteE,
    output logic [1:0]      ResultSrcE,
    output logic            MemWriteE,
    output logic            JumpE,
    output logic            BranchE,
    output logic [2:0]      ALUControlE,
    output logic            ALUSrcE,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    output logic [XLEN-1:0] ALUResult_E,
    output logic            zero
);

    id_ex_t     ctrl_d;
    id_ex_t     ctrl_e;
    logic [1:0] imm_src_d;
    logic [1:0] alu_op;
    alu_ctrl_e  alu_ctrl_d;

    // Main decoder; unknown opcodes decode to an all-zero NOP.
    always_comb begin
        ctrl_d    = '0;
        imm_src_d = 2'b00;
        alu_op    = 2'b00;
        case (op)
            OP_LOAD: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.alu_src    = 1'b1;
                ctrl_d.result_src = 2'b01;
            end
            OP_STORE: begin
                imm_src_d        = 2'b01;
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.mem_write = 1'b1;
            end
            OP_REG: begin
                ctrl_d.reg_write = 1'b1;
                alu_op           = 2'b10;
            end
            OP_BRANCH: begin
                imm_src_d     = 2'b10;
                ctrl_d.branch = 1'b1;
                alu_op        = 2'b01;
            end
            OP_IMM: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_src   = 1'b1;
                alu_op           = 2'b10;
            end
            OP_JAL: begin
                ctrl_d.reg_write  = 1'b1;
                imm_src_d         = 2'b11;
                ctrl_d.result_src = 2'b10;
                ctrl_d.jump       = 1'b1;
            end
            default: ;
        endcase
        ctrl_d.alu_control = alu_ctrl_d;
    end

    // ALU decoder; only R-type with funct7b5 set turns funct3=000 into sub.
    always_comb begin
        alu_ctrl_d = ALU_ADD;
        unique case (1'b1)
            (alu_op == 2'b00): alu_ctrl_d = ALU_ADD;
            (alu_op == 2'b01): alu_ctrl_d = ALU_SUB;
            default: begin
                case (funct3)
                    3'b000: begin
                        if ({op[5], funct7b5} == 2'b11) begin
                            alu_ctrl_d = ALU_SUB;
                        end else begin
                            alu_ctrl_d = ALU_ADD;
                        end
                    end
                    3'b010:  alu_ctrl_d = ALU_SLT;
                    3'b100:  alu_ctrl_d = ALU_XOR;
                    3'b110:  alu_ctrl_d = ALU_OR;
                    3'b111:  alu_ctrl_d = ALU_AND;
                    default: alu_ctrl_d = ALU_ADD;
                endcase
            end
        endcase
    end

    assign RegWriteD   = ctrl_d.reg_write;
    assign ResultSrcD  = ctrl_d.result_src;
    assign MemWriteD   = ctrl_d.mem_write;
    assign JumpD       = ctrl_d.jump;
    assign BranchD     = ctrl_d.branch;
    assign ALUControlD = ctrl_d.alu_control;
    assign ALUSrcD     = ctrl_d.alu_src;
    assign ImmSrcD     = imm_src_d;

    // A flush loads the same all-zero bubble as reset.
    always_ff @(posedge clk) begin
        if (rst || flush_e) begin
            ctrl_e <= '0;
        end else begin
            ctrl_e <= ctrl_d;
        end
    end

    assign RegWriteE   = ctrl_e.reg_write;
    assign ResultSrcE  = ctrl_e.result_src;
    assign MemWriteE   = ctrl_e.mem_write;
    assign JumpE       = ctrl_e.jump;
    assign BranchE     = ctrl_e.branch;
    assign ALUControlE = ctrl_e.alu_control;
    assign ALUSrcE     = ctrl_e.alu_src;

    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] diff;
    logic            lt;

    assign sum  = SrcAE + SrcBE;
    assign diff = SrcAE - SrcBE;
    assign lt   = $signed(SrcAE) < $signed(SrcBE);

    always_comb begin
        ALUResult_E = '0;
        case (ctrl_e.alu_control)
            ALU_ADD: ALUResult_E = sum;
            ALU_SUB: ALUResult_E = diff;
            ALU_AND: ALUResult_E = SrcAE & SrcBE;
            ALU_OR:  ALUResult_E = SrcAE | SrcBE;
            ALU_XOR: ALUResult_E = SrcAE ^ SrcBE;
            ALU_SLT: ALUResult_E = {{(XLEN-1){1'b0}}, lt};
            default: ALUResult_E = '0;
        endcase
    end

    assign zero = (ALUResult_E == '0);

endmodule

// File: tb/tb_rv_decode_ex_ctrl.sv
// Randomised self-checking bench for rv_decode_ex_ctrl against a
// table-driven decode model and an arithmetic ALU model.
module tb_rv_decode_ex_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_e;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
    logic [1:0]  ResultSrcD, ImmSrcD;
    logic [2:0]  ALUControlD;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] SrcAE, SrcBE, ALUResult_E;
    logic        zero;

    always #5 clk = ~clk;

    rv_decode_ex_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .flush_e(flush_e),
        .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD),
        .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
        .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD),
        .ImmSrcD(ImmSrcD),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
        .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
        .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
        .SrcAE(SrcAE), .SrcBE(SrcBE),
        .ALUResult_E(ALUResult_E), .zero(zero)
    );

    // Packed as {reg_write, result_src, mem_write, jump, branch, alu_ctrl, alu_src}
    typedef logic [9:0] ctl_t;

    int n_chk  = 0;
    int n_fail = 0;

    ctl_t exp_d, exp_e, pending;
    logic [1:0] exp_imm;
    bit   have_pending = 0;
    bit   e_known = 0;

    logic [6:0]  tbl_op  [6];
    logic [10:0] tbl_row [6];

    initial begin
        // RegWrite,ImmSrc,ALUSrc,MemWrite,ResultSrc,Branch,ALUOp,Jump
        tbl_op[0] = 7'b0000011; tbl_row[0] = 11'b1_00_1_0_01_0_00_0;
        tbl_op[1] = 7'b0100011; tbl_row[1] = 11'b0_01_1_1_00_0_00_0;
        tbl_op[2] = 7'b0110011; tbl_row[2] = 11'b1_00_0_0_00_0_10_0;
        tbl_op[3] = 7'b1100011; tbl_row[3] = 11'b0_10_0_0_00_1_01_0;
        tbl_op[4] = 7'b0010011; tbl_row[4] = 11'b1_00_1_0_00_0_10_0;
        tbl_op[5] = 7'b1101111; tbl_row[5] = 11'b1_11_0_0_10_0_00_1;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_d(output ctl_t c, output logic [1:0] imm);
        logic [10:0] row;
        logic [1:0]  aop;
        logic [2:0]  ac;
        row = '0;
        for (int i = 0; i < 6; i++)
            if (tbl_op[i] == op) row = tbl_row[i];
        aop = row[2:1];
        if (aop == 2'd0) ac = 3'd0;
        else if (aop == 2'd1) ac = 3'd1;
        else begin
            case (funct3)
                3'd0: ac = (op[5] && funct7b5) ? 3'd1 : 3'd0;
                3'd2: ac = 3'd5;
                3'd4: ac = 3'd4;
                3'd6: ac = 3'd3;
                3'd7: ac = 3'd2;
                default: ac = 3'd0;
            endcase
        end
        imm = row[9:8];
        c = {row[10], row[5:4], row[6], row[0], row[3], ac, row[7]};
    endtask

    function automatic logic [31:0] model_alu(logic [2:0] ac,
                                              logic [31:0] a,
                                              logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (ac)
            3'd0: return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
            3'd1: return 32'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000);
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return (sa < sb) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // One cycle: advance the E model at the edge, drive mid-cycle, compare.
    task automatic cyc(input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, input logic fl, input logic r,
                       input logic [31:0] a, input logic [31:0] b);
        ctl_t d_act, e_act;
        logic [31:0] res;
        @(posedge clk);
        if (have_pending) begin
            exp_e = pending;
            e_known = 1;
        end
        @(negedge clk);
        op = o; funct3 = f3; funct7b5 = f7;
        flush_e = fl; rst = r; SrcAE = a; SrcBE = b;
        #1;
        model_d(exp_d, exp_imm);
        d_act = {RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD,
                 ALUControlD, ALUSrcD};
        chk("d_ctrl", 32'(d_act), 32'(exp_d));
        chk("d_imm", 32'(ImmSrcD), 32'(exp_imm));
        if (e_known) begin
            e_act = {RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE,
                     ALUControlE, ALUSrcE};
            chk("e_ctrl", 32'(e_act), 32'(exp_e));
            res = model_alu(exp_e[3:1], a, b);
            chk("alu_res", ALUResult_E, res);
            chk("alu_zero", 32'(zero), 32'(res == 0));
        end
        pending = (r || fl) ? ctl_t'(0) : exp_d;
        have_pending = 1;
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    localparam logic [6:0] R_OP  = 7'b0110011;
    localparam logic [6:0] LW_OP = 7'b0000011;
    localparam logic [6:0] SW_OP = 7'b0100011;
    localparam logic [6:0] J_OP  = 7'b1101111;
    localparam logic [6:0] BAD   = 7'b1111111;

    initial begin
        logic [6:0]  o;
        logic [31:0] a, b;
        rst = 1; flush_e = 0; op = 0; funct3 = 0; funct7b5 = 0;
        SrcAE = 0; SrcBE = 0;

        cyc(BAD, 3'd0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
        cyc(R_OP, 3'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("lit_rst_regwe", 32'(RegWriteE), 32'd0);
        chk("lit_sub_d", 32'(ALUControlD), 32'd1);
        chk("lit_sub_rw", 32'(RegWriteD), 32'd1);
        chk("lit_sub_src", 32'(ALUSrcD), 32'd0);
        cyc(LW_OP, 3'd2, 1'b0, 1'b0, 1'b0, 32'd5, 32'd5);
        chk("lit_sub_e", 32'(ALUControlE), 32'd1);
        chk("lit_5m5", ALUResult_E, 32'd0);
        chk("lit_5m5_z", 32'(zero), 32'd1);
        chk("lit_lw_rs", 32'(ResultSrcD), 32'd1);
        chk("lit_lw_as", 32'(ALUSrcD), 32'd1);
        chk("lit_lw_imm", 32'(ImmSrcD), 32'd0);
        cyc(J_OP, 3'd0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1);
        chk("lit_add_wrap", ALUResult_E, 32'd0);
        chk("lit_add_z", 32'(zero), 32'd1);
        chk("lit_jal_j", 32'(JumpD), 32'd1);
        chk("lit_jal_rs", 32'(ResultSrcD), 32'd2);
        chk("lit_jal_imm", 32'(ImmSrcD), 32'd3);
        cyc(SW_OP, 3'd2, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        cyc(R_OP, 3'd2, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("lit_flush_mw", 32'(MemWriteE), 32'd0);
        chk("lit_flush_rw", 32'(RegWriteE), 32'd0);
        cyc(R_OP, 3'd7, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1);
        chk("lit_slt1", ALUResult_E, 32'd1);
        cyc(R_OP, 3'd6, 1'b0, 1'b0, 1'b0, 32'hF0F0, 32'h0FF0);
        chk("lit_and", ALUResult_E, 32'h00F0);
        cyc(R_OP, 3'd4, 1'b0, 1'b0, 1'b0, 32'hF0F0, 32'h0FF0);
        chk("lit_or", ALUResult_E, 32'hFFF0);
        cyc(R_OP, 3'd2, 1'b0, 1'b0, 1'b0, 32'hF0F0, 32'h0FF0);
        chk("lit_xor", ALUResult_E, 32'hFF00);
        cyc(BAD, 3'd7, 1'b1, 1'b0, 1'b0, 32'd1, 32'hFFFF_FFFF);
        chk("lit_slt0", ALUResult_E, 32'd0);
        chk("lit_bad_d", 32'({RegWriteD, ResultSrcD, MemWriteD, JumpD,
            BranchD, ALUControlD, ALUSrcD, ImmSrcD}), 32'd0);
        cyc(SW_OP, 3'd0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
        chk("lit_bad_e", 32'({RegWriteE, ResultSrcE, MemWriteE, JumpE,
            BranchE, ALUControlE, ALUSrcE}), 32'd0);
        cyc(SW_OP, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("lit_rst_mw", 32'(MemWriteE), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) o = 7'($urandom);
            else o = tbl_op[$urandom_range(0, 5)];
            a = pick_val();
            b = ($urandom_range(0, 9) == 0) ? a : pick_val();
            cyc(o, 3'($urandom), 1'($urandom),
                $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0,
                a, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
